debounce_fsm: RTL and testbench
===============================

DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 Parameter N, default 19, sets prescaler width; sample-tick period is 2**N clocks.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 sw  input  1  raw asynchronous switch/button level, may bounce.
REQ-005 db_level  output  1  debounced level of sw.
REQ-006 db_tick  output  1  one-clock pulse on each debounced 0->1 transition; drives a downstream counter enable.

Function
REQ-007 sw SHALL pass through a 2-flop synchronizer; FSM uses only the second-stage output sw_s.
REQ-008 Free-running N-bit prescaler SHALL increment by 1 every clock, wrapping 2**N-1 -> 0; m_tick SHALL be high when the prescaler equals 0.
REQ-009 FSM states: ZERO, WAIT1_1, WAIT1_2, WAIT1_3, ONE, WAIT0_1, WAIT0_2, WAIT0_3.
REQ-010 ZERO: sw_s=1 -> WAIT1_1; else stay.
REQ-011 WAIT1_k (k=1,2): sw_s=0 -> ZERO; else m_tick=1 -> WAIT1_(k+1); else stay.
REQ-012 WAIT1_3: sw_s=0 -> ZERO; else m_tick=1 -> ONE; else stay.
REQ-013 ONE: sw_s=0 -> WAIT0_1; else stay.
REQ-014 WAIT0_k (k=1,2): sw_s=1 -> ONE; else m_tick=1 -> WAIT0_(k+1); else stay.
REQ-015 WAIT0_3: sw_s=1 -> ONE; else m_tick=1 -> ZERO; else stay.
REQ-016 When sw_s and m_tick both change state in the same cycle, the sw_s check SHALL take priority (abort to ZERO/ONE).
REQ-017 db_level SHALL be registered: 1 in ONE and WAIT0_1..3, 0 in ZERO and WAIT1_1..3.
REQ-018 db_tick SHALL be registered and high for exactly the first clock in which db_level reads 1 after a WAIT1_3 -> ONE transition; low otherwise.
REQ-019 Return WAIT0_k -> ONE SHALL NOT assert db_tick.
REQ-020 Debounce latency: db_level rises between 2*2**N+3 and 3*2**N+2 clocks after the first edge sampling sw=1, given sw held stable; same bounds for falling.
REQ-021 Any sw_s pulse not spanning three consecutive m_ticks SHALL be rejected with no db_level change and no db_tick.
REQ-022 Prescaler SHALL never be reset by FSM activity; only by reset.

Reset
REQ-023 On reset=1 at a clock edge: state <= ZERO, prescaler <= 0, both synchronizer flops <= 0, db_level <= 0, db_tick <= 0.
REQ-024 Reset SHALL override all other transitions, including mid-WAIT states and the db_tick cycle.
REQ-025 m_tick SHALL be high in the first cycle after reset deasserts (prescaler = 0).

Verification (N=4, tick period 16)
REQ-026 reset=1 for 3 clocks, sw=0, release -> db_level=0, db_tick=0 for 100 clocks.
REQ-027 From ZERO, sw=1 held 80 clocks -> db_level=1 within 35..50 clocks after first edge sampling sw=1; exactly one db_tick pulse, coincident with the first db_level=1 cycle.
REQ-028 From ZERO, sw=1 for 10 clocks then 0 -> db_level stays 0, db_tick never asserted.
REQ-029 sw toggling every 3 clocks for 40 clocks then steady 1 -> exactly one db_tick, db_level stays 1 afterwards.
REQ-030 From ONE, sw=0 held 80 clocks -> db_level=0 within 35..50 clocks; no db_tick; sw=0 for 10 clocks then 1 leaves db_level=1 with no db_tick.
REQ-031 reset=1 for one clock while in WAIT1_2 -> next cycle db_level=0, db_tick=0, prescaler=0; with sw held 1, db_level rises within 35..50 clocks after reset release.

Source files
------------

// File: rtl/debounce_fsm.sv
// Switch debouncer: 2-flop synchronizer, free-running sample prescaler and an
// 8-state FSM that needs three consecutive sample ticks of a stable level to flip.
module debounce_fsm #(
    parameter int unsigned N = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    typedef enum logic [2:0] {
        StZero,
        StWait11,
        StWait12,
        StWait13,
        StOne,
        StWait01,
        StWait02,
        StWait03
    } state_e;

    state_e         state_q, state_d;
    logic           sync1_q, sync1_d;
    logic           sw_s_q, sw_s_d;
    logic [N-1:0]   presc_q, presc_d;
    logic           db_level_q, db_level_d;
    logic           db_tick_q, db_tick_d;
    logic           m_tick;

    assign m_tick = (presc_q == '0);

    always_comb begin
        sync1_d = sw;
        sw_s_d  = sync1_q;
        presc_d = presc_q + {{(N-1){1'b0}}, 1'b1};
        state_d = state_q;

        // A level change on sw_s always wins over a coincident sample tick.
        unique case (state_q)
            StZero:   if (sw_s_q) state_d = StWait11;
            StWait11: if (!sw_s_q) state_d = StZero;
                      else if (m_tick) state_d = StWait12;
            StWait12: if (!sw_s_q) state_d = StZero;
                      else if (m_tick) state_d = StWait13;
            StWait13: if (!sw_s_q) state_d = StZero;
                      else if (m_tick) state_d = StOne;
            StOne:    if (!sw_s_q) state_d = StWait01;
            StWait01: if (sw_s_q) state_d = StOne;
                      else if (m_tick) state_d = StWait02;
            StWait02: if (sw_s_q) state_d = StOne;
                      else if (m_tick) state_d = StWait03;
            StWait03: if (sw_s_q) state_d = StOne;
                      else if (m_tick) state_d = StZero;
        endcase

        db_level_d = (state_d == StOne) || (state_d == StWait01) ||
                     (state_d == StWait02) || (state_d == StWait03);
        // Only a confirmed rise pulses; bouncing back from WAIT0_k does not.
        db_tick_d  = (state_q == StWait13) && (state_d == StOne);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StZero;
            sync1_q    <= 1'b0;
            sw_s_q     <= 1'b0;
            presc_q    <= '0;
            db_level_q <= 1'b0;
            db_tick_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sw_s_q     <= sw_s_d;
            presc_q    <= presc_d;
            db_level_q <= db_level_d;
            db_tick_q  <= db_tick_d;
        end
    end

    assign db_level = db_level_q;
    assign db_tick  = db_tick_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm (N=4): table-driven segments, latency sequences, a
// reset-in-WAIT1_2 sequence and random bouncing compared against a tick-counting model.
module tb_debounce_fsm;

    localparam int unsigned N = 4;
    localparam int PERIOD = 1 << N;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw = 1'b0;
    logic db_level;
    logic db_tick;

    int checks = 0;
    int errors = 0;

    debounce_fsm #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    always #5 clk = ~clk;

    // Reference model: sync pipeline, cycle phase since reset, and a count of
    // sample ticks seen while the synchronized input disagrees with the level.
    logic m_sy1 = 1'b0, m_sy2 = 1'b0, m_level = 1'b0, m_tick_o = 1'b0;
    bit   m_wait = 1'b0, m_valid = 1'b0;
    int   m_nt = 0, m_pre = 0;

    task automatic model_edge(input logic r, input logic s);
        bit mt;
        logic ss;
        if (r) begin
            m_sy1 = 0; m_sy2 = 0; m_level = 0; m_tick_o = 0;
            m_wait = 0; m_nt = 0; m_pre = 0; m_valid = 1;
        end else begin
            mt = (m_pre == 0);
            ss = m_sy2;
            m_tick_o = 0;
            if (!m_wait) begin
                if (ss != m_level) begin
                    m_wait = 1;
                    m_nt = 0;
                end
            end else if (ss == m_level) begin
                m_wait = 0;
            end else if (mt) begin
                m_nt++;
                if (m_nt == 3) begin
                    m_level = ~m_level;
                    m_wait = 0;
                    m_tick_o = m_level;
                end
            end
            m_pre = (m_pre + 1) % PERIOD;
            m_sy2 = m_sy1;
            m_sy1 = s;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(reset, sw);
        #1;
        if (m_valid) begin
            chk("model db_level", int'(db_level), int'(m_level));
            chk("model db_tick", int'(db_tick), int'(m_tick_o));
        end
    endtask

    // Hold sw at val and measure the clocks until db_level follows.
    task automatic settle_latency(input logic val, input string name);
        int lat;
        int nticks;
        int tick_at_first;
        lat = 0;
        nticks = 0;
        tick_at_first = -1;
        sw = val;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (db_tick === 1'b1) nticks++;
            if (lat == 0 && db_level === val) begin
                lat = k;
                tick_at_first = int'(db_tick);
            end
        end
        checks++;
        if (lat < 35 || lat > 50) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 35..50", name, lat);
        end
        chk({name, " tick count"}, nticks, val ? 1 : 0);
        chk({name, " tick on first level cycle"}, tick_at_first, val ? 1 : 0);
        chk({name, " final level"}, int'(db_level), int'(val));
    endtask

    typedef struct {
        logic rst;
        logic sw;
        int   cycles;
        int   exp_ticks;
        logic exp_level;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nticks;
        bit reached;
        int run;

        vecs[0] = '{1'b1, 1'b0, 3,   0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 100, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 10,  0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 40,  0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 80,  1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 10,  0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 40,  0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 80,  0, 1'b0};

        for (int v = 0; v < 8; v++) begin
            reset = vecs[v].rst;
            sw = vecs[v].sw;
            nticks = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step();
                if (db_tick === 1'b1) nticks++;
            end
            chk($sformatf("vec%0d tick count", v), nticks, vecs[v].exp_ticks);
            chk($sformatf("vec%0d final level", v), int'(db_level), int'(vecs[v].exp_level));
        end

        // Toggling every 3 clocks never lasts three sample ticks; steady 1 then rises once.
        nticks = 0;
        for (int i = 0; i < 40; i++) begin
            sw = ((i / 3) % 2 == 0);
            step();
            if (db_tick === 1'b1) nticks++;
            chk("toggle level low", int'(db_level), 0);
        end
        sw = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (db_tick === 1'b1) nticks++;
        end
        chk("toggle tick count", nticks, 1);
        chk("toggle final level", int'(db_level), 1);

        settle_latency(1'b0, "fall");
        settle_latency(1'b1, "rise");
        settle_latency(1'b0, "fall2");

        // Reset while waiting in WAIT1_2.
        sw = 1'b1;
        reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            step();
            reached = m_wait && m_nt == 1 && !m_level;
        end
        chk("reached WAIT1_2", int'(reached), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid-wait reset db_level", int'(db_level), 0);
        chk("mid-wait reset db_tick", int'(db_tick), 0);
        chk("mid-wait reset prescaler", int'(dut.presc_q), 0);
        settle_latency(1'b1, "post-reset rise");

        // Random bouncing with occasional resets.
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                sw = 1'($urandom_range(0, 1));
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 70)
                                                  : $urandom_range(1, 20);
            end
            run--;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
